// File: rtl/lisnoc_router_input_port_if.sv
// Link and switch-side handshake bundle of a router input port.
// slave is the input port's view; master is the view of the link/crossbar driving it.
interface lisnoc_router_input_port_if #(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int vchannels       = 1,
    parameter int ports           = 5
);
    logic [flit_data_width+flit_type_width-1:0]             link_flit;
    logic [vchannels-1:0]                                   link_valid;
    logic [vchannels-1:0]                                   link_ready;
    logic [ports*vchannels-1:0]                             switch_request;
    logic [(flit_data_width+flit_type_width)*vchannels-1:0] switch_flit;
    logic [ports*vchannels-1:0]                             switch_read;

    modport slave (
        input  link_flit, link_valid, switch_read,
        output link_ready, switch_request, switch_flit
    );

    modport master (
        output link_flit, link_valid, switch_read,
        input  link_ready, switch_request, switch_flit
    );
endinterface

// File: rtl/lisnoc_router_input_port.sv
// Router input port: per-vchannel flit FIFO, header route lookup, route held until packet end.
// Optional LISNOC_ROUTER_INPUT_ERR_EN adds a saturating err_count of discarded flits/unroutable headers.
module lisnoc_router_input_port #(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int vchannels       = 1,
    parameter int ports           = 5,
    parameter int fifo_length     = 4,
    parameter int ph_dest_width   = 5,
    parameter logic [2**ph_dest_width*ports-1:0] lookup = '0
) (
    input  logic clk,
    input  logic rst,
    lisnoc_router_input_port_if.slave port_if
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
    ,
    output logic [7:0] err_count
`endif
);
    localparam int flit_width = flit_data_width + flit_type_width;
    localparam int ptr_w      = $clog2(fifo_length);
    localparam int cnt_w      = $clog2(fifo_length + 1);

    localparam logic [flit_type_width-1:0] TYPE_HEADER = flit_type_width'(1);
    localparam logic [flit_type_width-1:0] TYPE_LAST   = flit_type_width'(2);
    localparam logic [flit_type_width-1:0] TYPE_SINGLE = flit_type_width'(3);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DROP = 2'd2} state_t;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(fifo_length - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [ports-1:0]      req_v   [vchannels];
    logic [flit_width-1:0] flit_v  [vchannels];
    logic                  ready_v [vchannels];
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
    logic [vchannels-1:0]  ev_v;
`endif

    for (genvar v = 0; v < vchannels; v++) begin : g_vc
        logic [flit_width-1:0]      mem [fifo_length];
        logic [ptr_w-1:0]           rd_ptr, wr_ptr;
        logic [cnt_w-1:0]           count, count_nxt;
        logic                       ready_q;
        state_t                     state;
        logic [ports-1:0]           route;
        logic [flit_width-1:0]      head;
        logic [flit_type_width-1:0] head_type;
        logic [ph_dest_width-1:0]   dest;
        logic [ports-1:0]           entry;
        logic                       empty, push, pop, is_hdr, is_end;

        assign head      = mem[rd_ptr];
        assign empty     = (count == '0);
        assign head_type = head[flit_width-1 -: flit_type_width];
        assign dest      = head[flit_data_width-1 -: ph_dest_width];
        assign entry     = lookup[dest*ports +: ports];
        assign is_hdr    = (head_type == TYPE_HEADER) || (head_type == TYPE_SINGLE);
        assign is_end    = (head_type == TYPE_LAST) || (head_type == TYPE_SINGLE);
        assign push      = port_if.link_valid[v] & ready_q;

        // Stray body flits in IDLE are popped straight away; reads on ports outside the route are ignored.
        always_comb begin
            pop = 1'b0;
            unique case (state)
                IDLE:    pop = !empty && !is_hdr;
                ACTIVE:  pop = !empty && |(port_if.switch_read[v*ports +: ports] & route);
                DROP:    pop = !empty;
                default: pop = 1'b0;
            endcase
        end

        always_comb begin
            count_nxt = count;
            if (push && !pop)
                count_nxt = count + 1'b1;
            else if (!push && pop)
                count_nxt = count - 1'b1;
        end

        always_ff @(posedge clk) begin
            if (push)
                mem[wr_ptr] <= port_if.link_flit;
        end

        // ready is registered from the post-update count, so a full FIFO refuses a push even while popping.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                count   <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                ready_q <= 1'b0;
                state   <= IDLE;
                route   <= '0;
            end else begin
                count   <= count_nxt;
                ready_q <= (count_nxt < cnt_w'(fifo_length));
                if (push)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                unique case (state)
                    IDLE: begin
                        if (!empty && is_hdr) begin
                            route <= entry;
                            state <= (|entry) ? ACTIVE : DROP;
                        end
                    end
                    ACTIVE, DROP: begin
                        if (pop && is_end) begin
                            route <= '0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign req_v[v]   = (state == ACTIVE && !empty) ? route : '0;
        assign flit_v[v]  = empty ? '0 : head;
        assign ready_v[v] = ready_q;
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
        // An unroutable header is counted when looked up; its later pop in DROP is not counted again.
        assign ev_v[v] = (state == IDLE && !empty && (!is_hdr || ~|entry)) ||
                         (state == DROP && pop && !is_hdr);
`endif
    end

    always_comb begin
        port_if.switch_request = '0;
        port_if.switch_flit    = '0;
        port_if.link_ready     = '0;
        for (int v = 0; v < vchannels; v++) begin
            port_if.switch_request[v*ports +: ports]          = req_v[v];
            port_if.switch_flit[v*flit_width +: flit_width]   = flit_v[v];
            port_if.link_ready[v]                             = ready_v[v];
        end
    end

`ifdef LISNOC_ROUTER_INPUT_ERR_EN
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [8:0] n);
        logic [9:0] s;
        s = 10'(a) + 10'(n);
        return (s > 10'd255) ? 8'hff : s[7:0];
    endfunction

    logic [8:0] ev_sum;

    always_comb begin
        ev_sum = '0;
        for (int v = 0; v < vchannels; v++)
            ev_sum = ev_sum + 9'(ev_v[v]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_count <= '0;
        else
            err_count <= sat_add(err_count, ev_sum);
    end
`endif
endmodule

// File: doc/lisnoc_router_input_port.md
Name: lisnoc_router_input_port

Overview:
- Receiving end of a router link: accepts flits from the upstream link per virtual channel and buffers them in a per-vchannel FIFO.
- Decodes the destination from each header flit through a static lookup table and drives switch requests towards exactly one output port.
- Holds that route until the packet's last flit is read by the switch.
- Sits between the link and the crossbar, mirroring the router output port on the far side of the switch.

Parameters:
flit_data_width, 32, data bits per flit
flit_type_width, 2, type bits in flit MSBs (HEADER=01, PAYLOAD=00, LAST=10, SINGLE=11)
vchannels, 1, number of virtual channels
ports, 5, number of router output ports
fifo_length, 4, per-vchannel buffer depth in flits (>=2)
ph_dest_width, 5, destination field width at flit data MSBs
lookup, {2**ph_dest_width*ports{1'b0}}, routing table; entry d = lookup[d*ports +: ports], one-hot or zero

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (0 = reset)
link_flit  in  flit_data_width+flit_type_width  incoming flit
link_valid  in  vchannels  flit valid for vchannel v
link_ready  out  vchannels  vchannel v can accept a flit
switch_request  out  ports*vchannels  bit v*ports+p: vchannel v requests output p
switch_flit  out  (flit_data_width+flit_type_width)*vchannels  head flit of vchannel v
switch_read  in  ports*vchannels  bit v*ports+p: output p consumed vchannel v head flit

Behaviour:
- Reset (rst=0, async): FIFOs emptied, all states IDLE, route registers 0, link_ready=0, switch_request=0, switch_flit=0.
- Vchannels are independent. Per vchannel v:
- Link push:
  - Push when link_valid[v] & link_ready[v].
  - link_ready[v] = registered (count < fifo_length); first high cycle is the one after reset release.
  - No bypass: a flit pushed in cycle N is at the FIFO head in cycle N+1.
  - Pop and push in the same cycle when full: push is refused, since ready reflects the count at cycle start.
- switch_flit slice v always shows the FIFO head; 0 when empty.
- Destination field: dest = head flit data[flit_data_width-1 -: ph_dest_width].
- State IDLE:
  - Head is HEADER or SINGLE: route <= lookup entry for dest. Next state is ACTIVE if the entry is non-zero, else DROP.
  - Head is PAYLOAD or LAST (protocol error): flit is popped and discarded; state stays IDLE.
  - FIFO empty: stay IDLE.
- State ACTIVE:
  - switch_request[v*ports +: ports] = route when FIFO non-empty, else 0.
  - Pop when (switch_read[v*ports +: ports] & route) != 0. switch_read bits outside route are ignored.
  - Popped flit LAST or SINGLE: next state IDLE; route cleared.
- State DROP:
  - No requests.
  - Pop one flit per cycle while non-empty.
  - Popped flit LAST or SINGLE: next state IDLE.
- Latency:
  - Header pushed in cycle N is routed at the N+1 edge; first request in N+2.
  - Back-to-back packets: the next header is routed the cycle after the previous LAST pops, giving a one-cycle request bubble.
- Empty FIFO mid-packet: requests drop to 0; route and state are held.
- Reset mid-packet: everything is flushed and state returns to IDLE. Flits of the partial packet still upstream are later discarded as protocol errors.

Optional Feature:
- Macro LISNOC_ROUTER_INPUT_ERR_EN adds output err_count (8 bits, shared by all vchannels).
- err_count increments once per flit discarded in IDLE or DROP, and once per header with a zero route. It saturates at 255 and resets to 0.
- With more than one discard in the same cycle, it adds the number of events, still saturating.
- Without the macro: port absent; discard behaviour unchanged.

Test Plan:
- Route a 3-flit packet: vchannels=1, lookup entry 3 = 5'b00100. Push HEADER(dest=3), PAYLOAD, LAST back-to-back, switch_read[2] held high → switch_request=00100 from 2 cycles after the header push; 3 pops; request 0 after LAST; state IDLE.
- Fill and stall: fifo_length=4, 6 flits offered, switch_read=0 → link_ready low after 4 accepts; one read re-raises link_ready the next cycle; order preserved.
- Wrong and partial reads: ACTIVE on port 1, switch_read pulses on port 3 → no pop; a pulse on port 1 pops exactly one flit.
- Zero route and stray flit: header to a dest with a zero lookup entry followed by 2 PAYLOAD and a LAST → all 4 dropped, no requests. A lone PAYLOAD in IDLE is dropped. err_count=5 with the macro.
- Two vchannels: interleaved pushes to v0 (dest→port0) and v1 (dest→port4) → requests 00001 and 10000 concurrent; independent pops.
- Reset mid-packet: after HEADER+PAYLOAD of a packet, rst=0 for 1 cycle → outputs 0 immediately; after release, a SINGLE flit routes normally.
